a2d_resp: RTL and testbench

Synthesizable SPI responder that models the 8-channel 12-bit A2D converter on the A2D_SS_n/A2D_SCLK/A2D_MOSI/A2D_MISO bus. It decodes the channel address the master shifts in, and returns the 12-bit value of that channel during the following frame. It sits at the sensor end of the bus, in the full-system testbench and in FPGA loopback builds. Channel values are supplied on a port.

---
 rtl/a2d_pkg.sv | 11 +
 rtl/a2d_resp_if.sv | 9 +
 rtl/spi_edge_sync.sv | 37 +++
 rtl/a2d_resp.sv | 72 +++++++
 tb/tb_a2d_resp.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/a2d_pkg.sv
// a2d_pkg: shared sizes and FSM encoding for the A2D SPI responder.
package a2d_pkg;
   localparam int NUM_CH   = 8;
   localparam int DATA_W   = 12;
   localparam int FRM_W    = 16;
   localparam int ADDR_MSB = 13;
   localparam int ADDR_LSB = 11;
   localparam int ADDR_W   = $clog2(NUM_CH);
   localparam int CNT_W    = $clog2(FRM_W) + 1;
   typedef enum logic [1:0] {IDLE, LOAD, XFER, DONE} a2d_state_t;
endpackage

// File: rtl/a2d_resp_if.sv
// a2d_resp_if: A2D SPI bus between the master and the responder.
interface a2d_resp_if;
   logic SS_n;
   logic SCLK;
   logic MOSI;
   logic MISO;
   modport master (output SS_n, SCLK, MOSI, input MISO);
   modport slave  (input SS_n, SCLK, MOSI, output MISO);
endinterface

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: double-flop synchronizer with registered SCLK/SS_n edge pulses.
module spi_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic i_ss_n,
   input  logic i_sclk,
   input  logic i_mosi,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic ss_fall,
   output logic ss_rise,
   output logic mosi_s
);
   // [0] first stage, [1] synchronized, [2] previous synchronized sample
   logic [2:0] r_ss;
   logic [2:0] r_sclk;
   logic [1:0] r_mosi;
   assign mosi_s = r_mosi[1];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_ss      <= 3'b111;
         r_sclk    <= 3'b000;
         r_mosi    <= 2'b00;
         sclk_rise <= 1'b0;
         sclk_fall <= 1'b0;
         ss_fall   <= 1'b0;
         ss_rise   <= 1'b0;
      end else begin
         r_ss      <= {r_ss[1:0], i_ss_n};
         r_sclk    <= {r_sclk[1:0], i_sclk};
         r_mosi    <= {r_mosi[0], i_mosi};
         sclk_rise <= r_sclk[1] & ~r_sclk[2];
         sclk_fall <= ~r_sclk[1] & r_sclk[2];
         ss_fall   <= ~r_ss[1] & r_ss[2];
         ss_rise   <= r_ss[1] & ~r_ss[2];
      end
endmodule

// File: rtl/a2d_resp.sv
// a2d_resp: SPI responder modelling an 8-channel 12-bit A2D converter;
// returns the channel requested in the previous complete frame.
module a2d_resp
   import a2d_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   a2d_resp_if.slave                spi,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic [ADDR_W-1:0]        chnl,
   output logic                     frm_done
);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(FRM_W);
   logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise, w_mosi_s;
   logic [DATA_W-1:0] w_word;
   a2d_state_t r_state;
   logic [FRM_W-1:0] r_tx;
   // bits above the address field would shift straight out, so they are not kept
   logic [ADDR_MSB:0] r_rx;
   logic [CNT_W-1:0] r_cnt;
   spi_edge_sync u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_ss_n    (spi.SS_n),
      .i_sclk    (spi.SCLK),
      .i_mosi    (spi.MOSI),
      .sclk_rise (w_sclk_rise),
      .sclk_fall (w_sclk_fall),
      .ss_fall   (w_ss_fall),
      .ss_rise   (w_ss_rise),
      .mosi_s    (w_mosi_s)
   );
   assign w_word   = ch_data[chnl*DATA_W +: DATA_W];
   assign spi.MISO = (r_state inside {LOAD, XFER}) ? r_tx[FRM_W-1] : 1'b1;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state  <= IDLE;
         r_tx     <= '0;
         r_rx     <= '0;
         r_cnt    <= '0;
         chnl     <= '0;
         frm_done <= 1'b0;
      end else begin
         frm_done <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               r_state <= w_ss_fall ? LOAD : IDLE;
               if (w_ss_fall) begin
                  r_tx  <= {{(FRM_W-DATA_W){1'b0}}, w_word};
                  r_cnt <= '0;
               end
            end
            LOAD: r_state <= XFER;
            XFER: begin
               if (w_sclk_rise) begin
                  r_rx <= {r_rx[ADDR_MSB-1:0], w_mosi_s};
                  if (r_cnt != FULL) r_cnt <= r_cnt + 1'b1;
               end
               if (w_sclk_fall) r_tx <= {r_tx[FRM_W-2:0], 1'b0};
               // chnl and frm_done update on entry to DONE so they appear while in DONE
               if (w_ss_rise) begin
                  r_state <= DONE;
                  if (r_cnt == FULL) begin
                     chnl     <= r_rx[ADDR_MSB:ADDR_LSB];
                     frm_done <= 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_a2d_resp.sv
// tb_a2d_resp: directed vectors and corner-case sequences for a2d_resp.
module tb_a2d_resp;
   import a2d_pkg::*;
   typedef struct {
      logic [15:0] mosi;
      logic [15:0] miso;
      logic [2:0]  ch;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NUM_CH*DATA_W-1:0] ch_data;
   logic [NUM_CH*DATA_W-1:0] hook_data;
   logic [2:0] chnl;
   logic frm_done;
   int n_chk = 0, n_err = 0, done_cnt = 0, hook_bit = -1;
   vec_t tbl[10];
   a2d_resp_if spi();
   a2d_resp dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .spi      (spi.slave),
      .ch_data  (ch_data),
      .chnl     (chnl),
      .frm_done (frm_done)
   );
   always #5 clk = ~clk;
   always @(posedge clk) if (frm_done) done_cnt++;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic set_ch(input int n, input logic [11:0] v);
      ch_data[n*DATA_W +: DATA_W] = v;
   endtask
   task automatic xbit(input logic m, output logic s);
      spi.MOSI = m;
      repeat (8) @(negedge clk);
      spi.SCLK = 1'b1;
      s = spi.MISO;
      repeat (8) @(negedge clk);
      spi.SCLK = 1'b0;
   endtask
   task automatic frame(input logic [15:0] mo, input int nb, output logic [15:0] mi);
      logic s;
      mi = '0;
      @(negedge clk);
      spi.SS_n = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < nb; i++) begin
         if (i == hook_bit) ch_data = hook_data;
         xbit(mo[15-i], s);
         mi = {mi[14:0], s};
      end
      repeat (8) @(negedge clk);
      spi.SS_n = 1'b1;
      repeat (10) @(negedge clk);
   endtask
   task automatic run_frame(input string nm, input logic [15:0] mo, input logic [15:0] exp_mi,
                            input logic [2:0] exp_ch);
      logic [15:0] mi;
      int d0;
      d0 = done_cnt;
      frame(mo, 16, mi);
      chk({nm, " miso"}, 32'(mi), 32'(exp_mi));
      chk({nm, " chnl"}, 32'(chnl), 32'(exp_ch));
      chk({nm, " frm_done pulses"}, 32'(done_cnt - d0), 32'd1);
   endtask
   initial begin
      logic [15:0] mi;
      logic s;
      int d0;
      tbl = '{
         '{16'h0000, 16'h0000, 3'd0},
         '{16'h0800, 16'h0000, 3'd1},
         '{16'h57FF, 16'h0101, 3'd2},
         '{16'h1800, 16'h0202, 3'd3},
         '{16'h2000, 16'h0303, 3'd4},
         '{16'h2800, 16'h0404, 3'd5},
         '{16'h3000, 16'h0505, 3'd6},
         '{16'h3800, 16'h0606, 3'd7},
         '{16'hC7FF, 16'h0707, 3'd0},
         '{16'h3000, 16'h0000, 3'd6}
      };
      spi.SS_n = 1'b1;
      spi.SCLK = 1'b0;
      spi.MOSI = 1'b0;
      ch_data = '0;
      set_ch(0, 12'h7E1);
      set_ch(3, 12'hA5C);
      repeat (3) @(negedge clk);
      chk("reset miso", 32'(spi.MISO), 32'd1);
      chk("reset chnl", 32'(chnl), 32'd0);
      chk("reset frm_done", 32'(frm_done), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle miso", 32'(spi.MISO), 32'd1);
      run_frame("req ch3", 16'h1800, 16'h07E1, 3'd3);
      run_frame("read ch3", 16'h0000, 16'h0A5C, 3'd0);
      for (int n = 0; n < NUM_CH; n++) set_ch(n, 12'(n * 'h101));
      for (int i = 0; i < 10; i++) run_frame($sformatf("row%0d", i), tbl[i].mosi, tbl[i].miso, tbl[i].ch);
      d0 = done_cnt;
      frame(16'h2800, 7, mi);
      chk("abort frm_done", 32'(done_cnt - d0), 32'd0);
      chk("abort chnl", 32'(chnl), 32'd6);
      set_ch(2, 12'h123);
      run_frame("after abort", 16'h1000, 16'h0606, 3'd2);
      hook_data = ch_data;
      hook_data[2*DATA_W +: DATA_W] = 12'hFFF;
      hook_bit = 4;
      run_frame("data latch", 16'h2000, 16'h0123, 3'd4);
      hook_bit = -1;
      chk("latched data applied", 32'(ch_data[2*DATA_W +: DATA_W]), 32'hFFF);
      chk("idle miso 2", 32'(spi.MISO), 32'd1);
      set_ch(0, 12'h5A3);
      d0 = done_cnt;
      @(negedge clk);
      spi.SS_n = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 9; i++) xbit(1'b1, s);
      rst_n = 1'b0;
      #1;
      chk("midreset miso", 32'(spi.MISO), 32'd1);
      chk("midreset chnl", 32'(chnl), 32'd0);
      chk("midreset frm_done", 32'(frm_done), 32'd0);
      spi.SS_n = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("midreset no pulse", 32'(done_cnt - d0), 32'd0);
      d0 = done_cnt;
      spi.SS_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("ss latency 3clk", 32'(spi.MISO), 32'd1);
      @(negedge clk);
      chk("ss latency 4clk", 32'(spi.MISO), 32'd0);
      repeat (4) @(negedge clk);
      spi.SS_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("empty frame no pulse", 32'(done_cnt - d0), 32'd0);
      chk("empty frame chnl", 32'(chnl), 32'd0);
      run_frame("post reset", 16'h0000, 16'h05A3, 3'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
